// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory bus arbiter.
package mem_bus_pkg;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;
    typedef enum logic {OWN_IF, OWN_D} arb_owner_e;

    localparam logic [2:0] SIZE_B = 3'd0;
    localparam logic [2:0] SIZE_H = 3'd1;
    localparam logic [2:0] SIZE_W = 3'd2;
    localparam logic [2:0] SIZE_D = 3'd3;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between the fetch port and the data port; data has priority,
// a streak counter guarantees fetch progress and a watchdog ends hung transactions.
//
// state    | meaning
// ARB_IDLE | no transaction; pick a winner from pending requests and latch it
// ARB_BUSY | latched transaction on the bus; wait for bus_ready or timeout
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int unsigned XLEN         = 64,
    parameter int unsigned MAX_D_STREAK = 4,
    parameter int unsigned TIMEOUT      = 16
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic [XLEN-1:0] if_rdata,
    output logic            if_ready,
    output logic            if_error,
    input  logic            d_read,
    input  logic            d_write,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    input  logic [2:0]      d_size,
    input  logic            d_signed,
    output logic [XLEN-1:0] d_rdata,
    output logic            d_ready,
    output logic            d_error,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_wdata,
    output logic            bus_read_req,
    output logic            bus_write_req,
    output logic [2:0]      bus_size,
    output logic            bus_signed,
    input  logic [XLEN-1:0] bus_rdata,
    input  logic            bus_ready,
    input  logic            bus_error,
    output logic            busy
);

    localparam int unsigned TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned STW = $clog2(MAX_D_STREAK + 1);
    localparam logic [TW-1:0]  TIMER_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [STW-1:0] STREAK_MAX = STW'(MAX_D_STREAK);

    arb_state_e     state;
    arb_owner_e     owner;
    logic [STW-1:0] streak;
    logic [TW-1:0]  timer;

    logic d_pending;
    logic d_wins;
    logic timeout_hit;
    logic done;

    assign d_pending   = d_read | d_write;
    assign d_wins      = d_pending && !(if_req && (streak == STREAK_MAX));
    assign timeout_hit = (TIMEOUT != 0) && (state == ARB_BUSY) && (timer == TIMER_LAST) && !bus_ready;
    assign done        = (state == ARB_BUSY) && (bus_ready || timeout_hit);
    assign busy        = (state != ARB_IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= ARB_IDLE;
            owner         <= OWN_IF;
            streak        <= '0;
            timer         <= '0;
            bus_addr      <= '0;
            bus_wdata     <= '0;
            bus_read_req  <= 1'b0;
            bus_write_req <= 1'b0;
            bus_size      <= '0;
            bus_signed    <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    timer <= '0;
                    if (d_wins) begin
                        state         <= ARB_BUSY;
                        owner         <= OWN_D;
                        bus_addr      <= d_addr;
                        bus_wdata     <= d_wdata;
                        // simultaneous read and write resolves to a write
                        bus_write_req <= d_write;
                        bus_read_req  <= d_read & ~d_write;
                        bus_size      <= d_size;
                        bus_signed    <= d_signed;
                        if (!if_req) begin
                            streak <= '0;
                        end else if (streak != STREAK_MAX) begin
                            streak <= streak + 1'b1;
                        end
                    end else if (if_req) begin
                        state         <= ARB_BUSY;
                        owner         <= OWN_IF;
                        bus_addr      <= if_addr;
                        bus_wdata     <= '0;
                        bus_write_req <= 1'b0;
                        bus_read_req  <= 1'b1;
                        bus_size      <= SIZE_W;
                        bus_signed    <= 1'b0;
                        streak        <= '0;
                    end
                end
                ARB_BUSY: begin
                    if (done) begin
                        state         <= ARB_IDLE;
                        timer         <= '0;
                        bus_read_req  <= 1'b0;
                        bus_write_req <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    always_comb begin
        if_ready = 1'b0;
        if_error = 1'b0;
        if_rdata = '0;
        d_ready  = 1'b0;
        d_error  = 1'b0;
        d_rdata  = '0;
        if (done) begin
            if (owner == OWN_IF) begin
                if_ready = 1'b1;
                if_error = bus_ready ? bus_error : 1'b1;
                if_rdata = bus_ready ? bus_rdata : '0;
            end else begin
                d_ready = 1'b1;
                d_error = bus_ready ? bus_error : 1'b1;
                d_rdata = bus_ready ? bus_rdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (MAX_D_STREAK=4, TIMEOUT=16).
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        if_req;
    logic [63:0] if_addr;
    logic [63:0] if_rdata;
    logic        if_ready;
    logic        if_error;
    logic        d_read;
    logic        d_write;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic [2:0]  d_size;
    logic        d_signed;
    logic [63:0] d_rdata;
    logic        d_ready;
    logic        d_error;
    logic [63:0] bus_addr;
    logic [63:0] bus_wdata;
    logic        bus_read_req;
    logic        bus_write_req;
    logic [2:0]  bus_size;
    logic        bus_signed;
    logic [63:0] bus_rdata;
    logic        bus_ready;
    logic        bus_error;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter #(.XLEN(64), .MAX_D_STREAK(4), .TIMEOUT(16)) dut (
        .clk(clk), .resetn(resetn),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready), .if_error(if_error),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
        .d_signed(d_signed), .d_rdata(d_rdata), .d_ready(d_ready), .d_error(d_error),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_read_req(bus_read_req),
        .bus_write_req(bus_write_req), .bus_size(bus_size), .bus_signed(bus_signed),
        .bus_rdata(bus_rdata), .bus_ready(bus_ready), .bus_error(bus_error), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // advance one cycle; inputs are driven just after the edge, outputs checked at the falling edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        if_req = 0; if_addr = '0; d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
        d_size = '0; d_signed = 0; bus_rdata = '0; bus_ready = 0; bus_error = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [63:0] exp_addr [6];
        exp_addr = '{64'h300, 64'h300, 64'h300, 64'h300, 64'h200, 64'h300};

        idle_inputs();
        resetn = 0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_rreq", bus_read_req, 0);
        check("rst_wreq", bus_write_req, 0);
        check("rst_addr", bus_addr, 0);
        check("rst_ifrdy", if_ready, 0);
        check("rst_drdy", d_ready, 0);
        resetn = 1;
        tick();

        // fetch only
        if_req = 1; if_addr = 64'h100;
        tick();
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) begin bus_ready = 1; bus_rdata = 64'h13; end
            settle();
            check($sformatf("f_rreq_c%0d", c), bus_read_req, 1);
            check($sformatf("f_addr_c%0d", c), bus_addr, 64'h100);
            check($sformatf("f_size_c%0d", c), bus_size, 2);
            check($sformatf("f_rdy_c%0d", c), if_ready, (c == 3));
            if (c < 3) tick();
        end
        check("f_rdata", if_rdata, 64'h13);
        check("f_err", if_error, 0);
        check("f_drdy", d_ready, 0);
        tick();
        idle_inputs();
        settle();
        check("f_idle_rreq", bus_read_req, 0);
        check("f_idle_busy", busy, 0);
        check("f_idle_rdy", if_ready, 0);

        // simultaneous fetch and data read: data first, then fetch after the bubble
        if_req = 1; if_addr = 64'h200;
        d_read = 1; d_addr = 64'h300; d_size = 3'd1; d_signed = 1;
        tick();
        bus_ready = 1; bus_rdata = 64'hABCD;
        settle();
        check("p_d_addr", bus_addr, 64'h300);
        check("p_d_size", bus_size, 1);
        check("p_d_sign", bus_signed, 1);
        check("p_d_rdy", d_ready, 1);
        check("p_d_rdata", d_rdata, 64'hABCD);
        check("p_if_rdy0", if_ready, 0);
        tick();
        d_read = 0; bus_ready = 0;
        settle();
        check("p_bubble", busy, 0);
        check("p_bubble_rreq", bus_read_req, 0);
        tick();
        bus_ready = 1; bus_rdata = 64'h55;
        settle();
        check("p_f_addr", bus_addr, 64'h200);
        check("p_f_size", bus_size, 2);
        check("p_f_sign", bus_signed, 0);
        check("p_f_rdy", if_ready, 1);
        check("p_f_rdata", if_rdata, 64'h55);
        check("p_d_rdy0", d_ready, 0);
        tick();
        idle_inputs();
        settle();

        // starvation: both held, bus answers immediately
        if_req = 1; if_addr = 64'h200; d_read = 1; d_addr = 64'h300; d_size = 3'd2;
        bus_ready = 1; bus_rdata = 64'h99;
        for (int g = 0; g < 6; g++) begin
            tick();
            settle();
            check($sformatf("s_addr_g%0d", g), bus_addr, exp_addr[g]);
            check($sformatf("s_drdy_g%0d", g), d_ready, (exp_addr[g] == 64'h300));
            check($sformatf("s_frdy_g%0d", g), if_ready, (exp_addr[g] == 64'h200));
            tick();
            settle();
            check($sformatf("s_idle_g%0d", g), busy, 0);
        end
        idle_inputs();
        tick();

        // timeout on a write (read+write together resolves to write)
        d_read = 1; d_write = 1; d_addr = 64'h400; d_wdata = 64'hDEAD; d_size = 3'd3;
        tick();
        settle();
        check("t_wreq", bus_write_req, 1);
        check("t_rreq", bus_read_req, 0);
        check("t_wdata", bus_wdata, 64'hDEAD);
        check("t_size", bus_size, 3);
        for (int c = 2; c <= 16; c++) begin
            tick();
            settle();
            check($sformatf("t_drdy_c%0d", c), d_ready, (c == 16));
        end
        check("t_derr", d_error, 1);
        check("t_drdata", d_rdata, 0);
        check("t_ifrdy", if_ready, 0);
        tick();
        d_read = 0; d_write = 0;
        bus_ready = 1; bus_rdata = 64'h1234;
        settle();
        check("t_after_wreq", bus_write_req, 0);
        check("t_after_busy", busy, 0);
        check("t_late_rdy", d_ready, 0);
        tick();
        idle_inputs();
        settle();

        // bus error on a load
        d_read = 1; d_addr = 64'h500;
        tick();
        bus_ready = 1; bus_error = 1; bus_rdata = 64'h77;
        settle();
        check("e_drdy", d_ready, 1);
        check("e_derr", d_error, 1);
        check("e_drdata", d_rdata, 64'h77);
        check("e_ifrdy", if_ready, 0);
        tick();
        idle_inputs();
        settle();

        // reset asserted mid-transaction
        if_req = 1; if_addr = 64'h600;
        tick();
        settle();
        check("r_busy_pre", busy, 1);
        tick();
        bus_ready = 1; bus_rdata = 64'hFF;
        #1 resetn = 0;
        #1;
        check("r_busy", busy, 0);
        check("r_rreq", bus_read_req, 0);
        check("r_addr", bus_addr, 0);
        check("r_ifrdy", if_ready, 0);
        check("r_ifrdata", if_rdata, 0);
        idle_inputs();
        tick();
        resetn = 1;
        tick();
        settle();
        check("r_after_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
